// File: rtl/epu_mem_pkg.sv
// Shared types for the byte-wide RAM arbiter: FSM states,
// request length encodings, owner tags and byte-count helper.
package epu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    // 2'b11 is treated as a word access.
    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            LEN_BYTE: n = 3'd1;
            LEN_HALF: n = 3'd2;
            default:  n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide RAM port between instruction fetch
// (word reads) and the MEM stage (byte/half/word loads and stores).
// Multi-byte accesses go out one byte per cycle; completion is a
// one-cycle done pulse to the owning requester.
// Ports: clk_in/rst_in (sync, active-high), rdy_in (0 = pause);
//   if_req/if_addr -> if_done/if_data;
//   mem_req/we/len/addr/wdata -> mem_done/mem_rdata;
//   ram_a/ram_dout/ram_wr out, ram_din in (one-cycle read latency).
module mem_arbiter
    import epu_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    state_t            state;
    state_t            state_nxt;
    owner_t            owner;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rbuf;
    logic [DATA_W-1:0] rword;
    logic [2:0]        nbytes;
    logic [2:0]        idx_i;
    logic [2:0]        idx_j;
    logic              issue;
    logic              in_flight;
    logic              last_cap;
    logic              last_wr;

    // idx_i = next byte to issue, idx_j = next byte to capture.
    // A read byte is in flight whenever issue has run one ahead.
    always_comb begin
        issue     = (state == RD || state == WR) && (idx_i < nbytes);
        in_flight = (state == RD) && (idx_i > idx_j);
        last_cap  = in_flight && (idx_j == nbytes - 3'd1);
        last_wr   = (state == WR) && (idx_i == nbytes - 3'd1);
        rword     = rbuf | (DATA_W'(ram_din) << {idx_j[1:0], 3'b000});
    end

    always_comb begin
        state_nxt = state;
        if (rdy_in) begin
            case (state)
                IDLE: begin
                    priority case (1'b1)
                        mem_req: state_nxt = mem_we ? WR : RD;
                        if_req:  state_nxt = RD;
                        default: state_nxt = IDLE;
                    endcase
                end
                RD:      if (last_cap) state_nxt = GAP;
                WR:      if (last_wr) state_nxt = GAP;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        ram_a    = issue ? base + ADDR_W'(idx_i) : '0;
        ram_dout = '0;
        if (issue && state == WR) begin
            ram_dout = wdata[{idx_i[1:0], 3'b000} +: 8];
        end
        ram_wr   = issue && (state == WR) && rdy_in;
        if_done  = (state == GAP) && (owner == OWN_IF) && rdy_in;
        mem_done = (state == GAP) && (owner == OWN_MEM) && rdy_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            base      <= '0;
            wdata     <= '0;
            rbuf      <= '0;
            nbytes    <= '0;
            idx_i     <= '0;
            idx_j     <= '0;
            if_data   <= '0;
            mem_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (rdy_in) begin
                case (state)
                    IDLE: begin
                        idx_i <= '0;
                        idx_j <= '0;
                        rbuf  <= '0;
                        if (mem_req) begin
                            owner  <= OWN_MEM;
                            base   <= mem_addr;
                            nbytes <= len_to_bytes(mem_len);
                            wdata  <= mem_wdata;
                        end else if (if_req) begin
                            owner  <= OWN_IF;
                            base   <= if_addr;
                            nbytes <= 3'd4;
                        end
                    end
                    RD: begin
                        if (idx_i < nbytes) idx_i <= idx_i + 3'd1;
                        if (in_flight) begin
                            idx_j <= idx_j + 3'd1;
                            rbuf  <= rword;
                            if (last_cap) begin
                                if (owner == OWN_IF) if_data <= rword;
                                else                 mem_rdata <= rword;
                            end
                        end
                    end
                    WR: if (issue) idx_i <= idx_i + 3'd1;
                    default: ;
                endcase
            end else if (state == RD) begin
                // The byte on ram_din is lost; re-issue from the oldest
                // uncaptured one after resume.
                idx_i <= idx_j;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a byte RAM model.
// Cycle 0 is the IDLE cycle in which a request is sampled.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_len = 2'b00;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [7:0]  ram_din = '0;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    mem_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_a(ram_a), .ram_wr(ram_wr)
    );

    always #5 clk_in = ~clk_in;

    logic [7:0] ram [0:65535];

    always @(posedge clk_in) begin
        if (ram_wr) ram[ram_a[15:0]] <= ram_dout;
        ram_din <= ram[ram_a[15:0]];
    end

    typedef struct {
        logic [31:0] d;
        int          at;
    } exp_t;

    exp_t        exp_if[$];
    exp_t        exp_mem[$];
    logic [31:0] ea [int];
    logic        ew [int];
    logic [7:0]  ed [int];
    bit          stall [int];

    int cyc = 0;
    int t0 = 0;
    int n_total = 0;
    int n_bad = 0;
    bit mon_on = 1'b0;
    bit if_seen = 1'b0;
    bit mem_seen = 1'b0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, want, $time);
        end
    endtask

    always @(negedge clk_in) begin
        int rel;
        exp_t e;
        rel = cyc - t0;
        if (mon_on) begin
            if (ea.exists(rel)) chk("ram_a", ram_a, ea[rel]);
            if (ew.exists(rel)) chk("ram_wr", 32'(ram_wr), 32'(ew[rel]));
            if (ed.exists(rel)) chk("ram_dout", 32'(ram_dout), 32'(ed[rel]));
            if (if_done) begin
                if_seen = 1'b1;
                if (exp_if.size() == 0) begin
                    chk("if_unexp", 32'(if_done), 32'd0);
                end else begin
                    e = exp_if.pop_front();
                    chk("if_data", if_data, e.d);
                    chk("if_cyc", 32'(rel), 32'(e.at));
                end
            end
            if (mem_done) begin
                mem_seen = 1'b1;
                if (exp_mem.size() == 0) begin
                    chk("mem_unexp", 32'(mem_done), 32'd0);
                end else begin
                    e = exp_mem.pop_front();
                    chk("mem_rdata", mem_rdata, e.d);
                    chk("mem_cyc", 32'(rel), 32'(e.at));
                end
            end
        end
    end

    task automatic clear_exp();
        mon_on = 1'b0;
        ea.delete();
        ew.delete();
        ed.delete();
        stall.delete();
    endtask

    task automatic begin_test();
        @(posedge clk_in);
        #1;
        t0 = cyc;
        rdy_in = 1'b1;
        mon_on = 1'b1;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        if (if_seen) begin
            if_req = 1'b0;
            if_seen = 1'b0;
        end
        if (mem_seen) begin
            mem_req = 1'b0;
            mem_seen = 1'b0;
        end
        rdy_in = !stall.exists(cyc - t0);
    endtask

    task automatic run(input int budget);
        int k;
        k = 0;
        while ((if_req || mem_req || exp_if.size() > 0 ||
                exp_mem.size() > 0) && k < budget) begin
            step();
            k++;
        end
        chk("in_budget", 32'(k < budget), 32'd1);
        if (k >= budget) begin
            if_req = 1'b0;
            mem_req = 1'b0;
            exp_if.delete();
            exp_mem.delete();
        end
        step();
        step();
    endtask

    task automatic fetch(input logic [31:0] a);
        if_req = 1'b1;
        if_addr = a;
    endtask

    task automatic mem_op(input logic we, input logic [1:0] len,
                          input logic [31:0] a, input logic [31:0] wd);
        mem_req = 1'b1;
        mem_we = we;
        mem_len = len;
        mem_addr = a;
        mem_wdata = wd;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = 8'h00;
        ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05;
        ram[16'h0104] = 8'h93; ram[16'h0106] = 8'h10;
        ram[16'h1003] = 8'h80;
        ram[16'h0302] = 8'h55;
        ram[16'h0500] = 8'h11; ram[16'h0501] = 8'h22;
        ram[16'h0502] = 8'h33; ram[16'h0503] = 8'h44;
        ram[16'hFFFE] = 8'hA1; ram[16'hFFFF] = 8'hB2;
        ram[16'h0000] = 8'hC3; ram[16'h0001] = 8'hD4;

        @(posedge clk_in);
        @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_mem_done", 32'(mem_done), 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_ram_a", ram_a, 32'd0);
        chk("rst_ram_dout", 32'(ram_dout), 32'd0);
        chk("rst_ram_wr", 32'(ram_wr), 32'd0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        // word fetch
        clear_exp();
        for (int k = 1; k <= 4; k++) begin
            ea[k] = 32'h100 + 32'(k - 1);
            ew[k] = 1'b0;
        end
        ea[5] = 32'h0;
        exp_if.push_back('{32'h0000_0513, 6});
        begin_test();
        fetch(32'h100);
        run(40);

        // simultaneous store and fetch: MEM first
        clear_exp();
        ed[1] = 8'hEF; ed[2] = 8'hBE; ed[3] = 8'hAD; ed[4] = 8'hDE;
        for (int k = 1; k <= 4; k++) begin
            ea[k] = 32'h200 + 32'(k - 1);
            ew[k] = 1'b1;
        end
        ew[5] = 1'b0;
        ea[7] = 32'h104;
        ew[7] = 1'b0;
        exp_mem.push_back('{32'h0, 5});
        exp_if.push_back('{32'h0010_0093, 12});
        begin_test();
        fetch(32'h104);
        mem_op(1'b1, 2'b10, 32'h200, 32'hDEAD_BEEF);
        run(40);
        chk("ram_200", 32'(ram[16'h0200]), 32'hEF);
        chk("ram_203", 32'(ram[16'h0203]), 32'hDE);

        // byte load
        clear_exp();
        ea[1] = 32'h1003;
        ea[2] = 32'h0;
        exp_mem.push_back('{32'h0000_0080, 3});
        begin_test();
        mem_op(1'b0, 2'b00, 32'h1003, 32'h0);
        run(40);

        // half store: only two bytes written
        clear_exp();
        ew[1] = 1'b1; ew[2] = 1'b1; ew[3] = 1'b0;
        ed[1] = 8'hCD; ed[2] = 8'hAB;
        ea[2] = 32'h301;
        exp_mem.push_back('{32'h0000_0080, 3});
        begin_test();
        mem_op(1'b1, 2'b01, 32'h300, 32'h1234_ABCD);
        run(40);
        chk("ram_300", 32'(ram[16'h0300]), 32'hCD);
        chk("ram_301", 32'(ram[16'h0301]), 32'hAB);
        chk("ram_302", 32'(ram[16'h0302]), 32'h55);

        // fetch with one stall cycle in cycle 2
        clear_exp();
        ea[1] = 32'h500;
        ea[3] = 32'h500;
        ea[4] = 32'h501;
        ea[6] = 32'h503;
        stall[2] = 1'b1;
        exp_if.push_back('{32'h4433_2211, 8});
        begin_test();
        fetch(32'h500);
        run(40);

        // len=11 load across the address wrap
        clear_exp();
        ea[1] = 32'hFFFF_FFFE; ea[2] = 32'hFFFF_FFFF;
        ea[3] = 32'h0;         ea[4] = 32'h1;
        exp_mem.push_back('{32'hD4C3_B2A1, 6});
        begin_test();
        mem_op(1'b0, 2'b11, 32'hFFFF_FFFE, 32'h0);
        run(40);

        // reset in cycle 3 of a word store
        clear_exp();
        ew[1] = 1'b1; ew[2] = 1'b1; ew[3] = 1'b1;
        ed[3] = 8'h22;
        ew[4] = 1'b0; ea[4] = 32'h0;
        ew[5] = 1'b0; ea[5] = 32'h0;
        begin_test();
        mem_op(1'b1, 2'b10, 32'h400, 32'h1122_3344);
        step();
        step();
        step();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        mem_req = 1'b0;
        step();
        step();
        step();
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("ram_400", 32'(ram[16'h0400]), 32'h44);
        chk("ram_402", 32'(ram[16'h0402]), 32'h22);
        chk("ram_403", 32'(ram[16'h0403]), 32'h00);

        // fetch after reset
        clear_exp();
        ea[1] = 32'h100;
        ea[4] = 32'h103;
        exp_if.push_back('{32'h0000_0513, 6});
        begin_test();
        fetch(32'h100);
        run(40);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
